// File: rtl/tri_draw_ctrl_pkg.sv
// Shared definitions for the triangle/line draw sequencer:
// FSM state encoding, parameter defaults and command mode encodings.
package tri_draw_ctrl_pkg;

    localparam int COORD_W_DEF     = 8;
    localparam int SEG_TIMEOUT_DEF = 512;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic MODE_LINE = 1'b0;
    localparam logic MODE_TRI  = 1'b1;

    // A line has only seg0; a triangle closes with seg2 (V2->V0).
    function automatic logic is_last_seg(input logic m, input logic [1:0] seg);
        return (m == MODE_LINE) ? (seg == 2'd0) : (seg == 2'd2);
    endfunction

endpackage

// File: rtl/tri_draw_ctrl_seg_mux.sv
// Endpoint selector: picks the DrawLine endpoint pair for a segment.
// Ports: seg_i index, x*_i/y*_i latched vertices, a*_o start, b*_o end.
module seg_mux #(
    parameter int W = 8
) (
    input  logic [1:0]   seg_i,
    input  logic [W-1:0] x0_i,
    input  logic [W-1:0] y0_i,
    input  logic [W-1:0] x1_i,
    input  logic [W-1:0] y1_i,
    input  logic [W-1:0] x2_i,
    input  logic [W-1:0] y2_i,
    output logic [W-1:0] ax_o,
    output logic [W-1:0] ay_o,
    output logic [W-1:0] bx_o,
    output logic [W-1:0] by_o
);

    always_comb begin
        ax_o = x0_i;
        ay_o = y0_i;
        bx_o = x1_i;
        by_o = y1_i;
        case (seg_i)
            2'd1: begin
                ax_o = x1_i;
                ay_o = y1_i;
                bx_o = x2_i;
                by_o = y2_i;
            end
            2'd2: begin
                ax_o = x2_i;
                ay_o = y2_i;
                bx_o = x0_i;
                by_o = y0_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/tri_draw_ctrl.sv
// Sequencer driving the shared DrawLine rasteriser edge by edge.
// Ports: command (start/mode/vertices/abort), status (busy/done/err),
// DrawLine control (DL_*), framebuffer write (PIX_X/PIX_Y/PIX_WE).
module tri_draw_ctrl
    import tri_draw_ctrl_pkg::*;
#(
    parameter int COORD_W     = COORD_W_DEF,
    parameter int SEG_TIMEOUT = SEG_TIMEOUT_DEF
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    input  logic               start,
    input  logic               mode,
    input  logic [COORD_W-1:0] X_0,
    input  logic [COORD_W-1:0] Y_0,
    input  logic [COORD_W-1:0] X_1,
    input  logic [COORD_W-1:0] Y_1,
    input  logic [COORD_W-1:0] X_2,
    input  logic [COORD_W-1:0] Y_2,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               DL_EN,
    output logic [COORD_W-1:0] DL_X0,
    output logic [COORD_W-1:0] DL_Y0,
    output logic [COORD_W-1:0] DL_X1,
    output logic [COORD_W-1:0] DL_Y1,
    input  logic [COORD_W-1:0] DL_X_Out,
    input  logic [COORD_W-1:0] DL_Y_Out,
    input  logic               DL_finish,
    output logic [COORD_W-1:0] PIX_X,
    output logic [COORD_W-1:0] PIX_Y,
    output logic               PIX_WE
);

    localparam int CNT_W = $clog2(SEG_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEG_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [1:0]         seg_q, seg_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q;
    logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q, x2_q, y2_q;
    logic [COORD_W-1:0] pix_x_q, pix_y_q;
    logic               pix_we_q;
    logic               accept;
    logic               run_wr;

    assign accept = (state_q == ST_IDLE) && start;
    // Abort on the same edge suppresses the pixel capture.
    assign run_wr = (state_q == ST_RUN) && !abort;

    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    seg_d   = 2'd0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (DL_finish) begin
                    if (is_last_seg(mode_q, seg_q)) begin
                        state_d = ST_DONE;
                    end else begin
                        seg_d   = seg_q + 2'd1;
                        state_d = ST_LOAD;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            err_d   = err_q;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= ST_IDLE;
            seg_q    <= 2'd0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            mode_q   <= MODE_LINE;
            x0_q     <= '0;
            y0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            x2_q     <= '0;
            y2_q     <= '0;
            pix_x_q  <= '0;
            pix_y_q  <= '0;
            pix_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            seg_q    <= seg_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            pix_we_q <= run_wr;
            if (accept) begin
                mode_q <= mode;
                x0_q   <= X_0;
                y0_q   <= Y_0;
                x1_q   <= X_1;
                y1_q   <= Y_1;
                x2_q   <= X_2;
                y2_q   <= Y_2;
            end
            if (run_wr) begin
                pix_x_q <= DL_X_Out;
                pix_y_q <= DL_Y_Out;
            end
        end
    end

    seg_mux #(
        .W (COORD_W)
    ) u_seg_mux (
        .seg_i (seg_q),
        .x0_i  (x0_q),
        .y0_i  (y0_q),
        .x1_i  (x1_q),
        .y1_i  (y1_q),
        .x2_i  (x2_q),
        .y2_i  (y2_q),
        .ax_o  (DL_X0),
        .ay_o  (DL_Y0),
        .bx_o  (DL_X1),
        .by_o  (DL_Y1)
    );

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign err    = err_q;
    assign DL_EN  = (state_q == ST_RUN);
    assign PIX_X  = pix_x_q;
    assign PIX_Y  = pix_y_q;
    assign PIX_WE = pix_we_q;

endmodule

// File: tb/tb_tri_draw_ctrl.sv
// Scoreboard bench for tri_draw_ctrl with a behavioural DrawLine model.
// Expected pixel writes and done pulses are queued by stimulus and checked by a monitor.
module tb_tri_draw_ctrl;

    localparam int W  = 8;
    localparam int TO = 16;

    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] X_0 = '0, Y_0 = '0, X_1 = '0, Y_1 = '0, X_2 = '0, Y_2 = '0;
    logic         busy, done, err, DL_EN, DL_finish, PIX_WE;
    logic [W-1:0] DL_X0, DL_Y0, DL_X1, DL_Y1, DL_X_Out, DL_Y_Out, PIX_X, PIX_Y;

    always #5 ACLK = ~ACLK;

    tri_draw_ctrl #(
        .COORD_W     (W),
        .SEG_TIMEOUT (TO)
    ) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .start     (start),
        .mode      (mode),
        .X_0       (X_0),
        .Y_0       (Y_0),
        .X_1       (X_1),
        .Y_1       (Y_1),
        .X_2       (X_2),
        .Y_2       (Y_2),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .DL_EN     (DL_EN),
        .DL_X0     (DL_X0),
        .DL_Y0     (DL_Y0),
        .DL_X1     (DL_X1),
        .DL_Y1     (DL_Y1),
        .DL_X_Out  (DL_X_Out),
        .DL_Y_Out  (DL_Y_Out),
        .DL_finish (DL_finish),
        .PIX_X     (PIX_X),
        .PIX_Y     (PIX_Y),
        .PIX_WE    (PIX_WE)
    );

    typedef struct {
        bit is_done;
        int x;
        int y;
        bit er;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_chk = 0;
    bit   hold_fin = 0;
    bit   mon_en = 1;
    int   vx[3];
    int   vy[3];
    int   dl_i;
    int   dl_n;
    logic [15:0] dl_pt;

    function automatic int absi(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int npix(input int x0, input int y0, input int x1, input int y1);
        int dx, dy;
        dx = absi(x1 - x0);
        dy = absi(y1 - y0);
        return ((dx > dy) ? dx : dy) + 1;
    endfunction

    // Pixel i of the line x0,y0 -> x1,y1 (evenly stepped, endpoints exact).
    function automatic logic [15:0] pt(input int x0, input int y0,
                                       input int x1, input int y1, input int i);
        int n, px, py;
        n = npix(x0, y0, x1, y1);
        if (n == 1) begin
            px = x0;
            py = y0;
        end else begin
            px = x0 + ((x1 - x0) * i) / (n - 1);
            py = y0 + ((y1 - y0) * i) / (n - 1);
        end
        return {px[7:0], py[7:0]};
    endfunction

    // DrawLine model: restarts whenever EN is low, one pixel per enabled cycle.
    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)   dl_i <= 0;
        else if (!DL_EN) dl_i <= 0;
        else            dl_i <= dl_i + 1;
    end

    always_comb begin
        dl_n  = npix(int'(DL_X0), int'(DL_Y0), int'(DL_X1), int'(DL_Y1));
        dl_pt = pt(int'(DL_X0), int'(DL_Y0), int'(DL_X1), int'(DL_Y1),
                   (dl_i < dl_n) ? dl_i : dl_n - 1);
    end

    assign DL_X_Out  = dl_pt[15:8];
    assign DL_Y_Out  = dl_pt[7:0];
    assign DL_finish = DL_EN && (dl_i == dl_n - 1) && !hold_fin;

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic push(input bit d, input int x, input int y, input bit er, input int c);
        exp_t e;
        e.is_done = d;
        e.x = x;
        e.y = y;
        e.er = er;
        e.cyc = c;
        q.push_back(e);
    endtask

    task automatic check_reset_vals(input string tag);
        chk(busy == 0 && done == 0 && err == 0, {tag, "_status"},
            int'({busy, done, err}), 0);
        chk(DL_EN == 0 && PIX_WE == 0, {tag, "_en_we"}, int'({DL_EN, PIX_WE}), 0);
        chk({DL_X0, DL_Y0, DL_X1, DL_Y1} == '0, {tag, "_dl_pts"},
            int'({DL_X0, DL_Y0, DL_X1, DL_Y1}), 0);
        chk({PIX_X, PIX_Y} == '0, {tag, "_pix"}, int'({PIX_X, PIX_Y}), 0);
    endtask

    // Issue one command with vertices vx/vy; ab_seg >= 0 aborts in that segment
    // after ab_k of its pixels; to holds DL_finish low to force a timeout.
    task automatic do_cmd(input logic m, input int ab_seg, input int ab_k, input bit to);
        int t0, L, nseg, n, a, b, ab_cyc;
        logic [15:0] p;
        ab_cyc = -1;
        @(negedge ACLK);
        hold_fin = to;
        mode = m;
        X_0 = 8'(vx[0]); Y_0 = 8'(vy[0]);
        X_1 = 8'(vx[1]); Y_1 = 8'(vy[1]);
        X_2 = 8'(vx[2]); Y_2 = 8'(vy[2]);
        start = 1'b1;
        @(posedge ACLK);
        #1;
        start = 1'b0;
        t0 = cyc;
        nseg = m ? 3 : 1;
        L = 0;
        for (int s = 0; s < nseg; s++) begin
            a = s;
            b = (s + 1) % 3;
            n = npix(vx[a], vy[a], vx[b], vy[b]);
            if (to) begin
                for (int j = 0; j < TO; j++) begin
                    p = pt(vx[a], vy[a], vx[b], vy[b], (j < n) ? j : n - 1);
                    push(0, int'(p[15:8]), int'(p[7:0]), 0, t0 + L + 2 + j);
                end
                L += TO + 1;
                break;
            end
            if (s == ab_seg) begin
                for (int j = 0; j < ab_k; j++) begin
                    p = pt(vx[a], vy[a], vx[b], vy[b], j);
                    push(0, int'(p[15:8]), int'(p[7:0]), 0, t0 + L + 2 + j);
                end
                ab_cyc = t0 + L + 1 + ab_k;
                break;
            end
            for (int j = 0; j < n; j++) begin
                p = pt(vx[a], vy[a], vx[b], vy[b], j);
                push(0, int'(p[15:8]), int'(p[7:0]), 0, t0 + L + 2 + j);
            end
            L += n + 1;
        end
        if (ab_cyc < 0) push(1, 0, 0, to, t0 + L);

        @(negedge ACLK);
        chk(err == 0, "err_clear_on_start", int'(err), 0);
        chk(busy == 1, "busy_on_start", int'(busy), 1);
        start = 1'b1;
        X_0 = 8'($urandom_range(0, 255));
        @(negedge ACLK);
        start = 1'b0;

        if (ab_cyc >= 0) begin
            for (int w = 0; w < 5000 && cyc != ab_cyc; w++) @(negedge ACLK);
            chk(cyc == ab_cyc, "abort_reach", cyc, ab_cyc);
            abort = 1'b1;
            @(negedge ACLK);
            abort = 1'b0;
            chk(busy == 0, "busy_after_abort", int'(busy), 0);
            chk(DL_EN == 0, "dl_en_after_abort", int'(DL_EN), 0);
            repeat (3) @(negedge ACLK);
        end else begin
            int w;
            for (w = 0; w < 3000 && busy; w++) @(negedge ACLK);
            chk(w < 3000, "idle_wait", w, 3000);
        end
        chk(q.size() == 0, "queue_drained", q.size(), 0);
        q.delete();
        hold_fin = 0;
    endtask

    task automatic set_v(input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2);
        vx[0] = x0; vy[0] = y0;
        vx[1] = x1; vy[1] = y1;
        vx[2] = x2; vy[2] = y2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        fork
            forever begin
                @(negedge ACLK);
                if (ARESETN && mon_en) begin
                    if (PIX_WE) begin
                        if (q.size() == 0 || q[0].is_done) begin
                            chk(0, "unexpected_pix", int'({PIX_X, PIX_Y}), -1);
                        end else begin
                            exp_t e;
                            e = q.pop_front();
                            chk(int'(PIX_X) == e.x, "pix_x", int'(PIX_X), e.x);
                            chk(int'(PIX_Y) == e.y, "pix_y", int'(PIX_Y), e.y);
                            chk(cyc == e.cyc, "pix_cycle", cyc, e.cyc);
                        end
                    end
                    if (done) begin
                        if (q.size() == 0 || !q[0].is_done) begin
                            chk(0, "unexpected_done", cyc, -1);
                        end else begin
                            exp_t e;
                            e = q.pop_front();
                            chk(err == e.er, "done_err", int'(err), int'(e.er));
                            chk(cyc == e.cyc, "done_cycle", cyc, e.cyc);
                        end
                    end
                end
            end
        join_none

        #1;
        check_reset_vals("reset");
        #11;
        ARESETN = 1'b1;

        set_v(1, 5, 0, 0, 0, 0);
        do_cmd(0, -1, 0, 0);
        set_v(0, 0, 4, 0, 0, 3);
        do_cmd(1, -1, 0, 0);
        set_v(7, 7, 7, 7, 7, 7);
        do_cmd(1, -1, 0, 0);
        set_v(0, 0, 15, 0, 0, 0);
        do_cmd(0, -1, 0, 0);
        set_v(2, 3, 9, 4, 5, 12);
        do_cmd(1, -1, 0, 1);
        @(negedge ACLK);
        chk(err == 1, "err_sticky", int'(err), 1);
        set_v(0, 0, 6, 2, 3, 9);
        do_cmd(1, 1, 3, 0);

        for (int it = 0; it < 30; it++) begin
            logic m;
            int ns, sg, n;
            m = 1'($urandom_range(0, 1));
            for (int k = 0; k < 3; k++) begin
                vx[k] = $urandom_range(0, 14);
                vy[k] = $urandom_range(0, 14);
            end
            ns = m ? 3 : 1;
            if ($urandom_range(0, 3) == 0) begin
                sg = $urandom_range(0, ns - 1);
                n = npix(vx[sg], vy[sg], vx[(sg + 1) % 3], vy[(sg + 1) % 3]);
                do_cmd(m, sg, $urandom_range(0, n - 1), 0);
            end else begin
                do_cmd(m, -1, 0, 0);
            end
        end

        mon_en = 0;
        set_v(0, 0, 10, 0, 0, 10);
        @(negedge ACLK);
        mode = 1'b1;
        X_0 = 8'(vx[0]); Y_0 = 8'(vy[0]);
        X_1 = 8'(vx[1]); Y_1 = 8'(vy[1]);
        X_2 = 8'(vx[2]); Y_2 = 8'(vy[2]);
        start = 1'b1;
        @(posedge ACLK);
        #1;
        start = 1'b0;
        repeat (4) @(negedge ACLK);
        chk(DL_EN == 1, "run_before_reset", int'(DL_EN), 1);
        #2;
        ARESETN = 1'b0;
        #1;
        check_reset_vals("mid_run_reset");
        @(negedge ACLK);
        ARESETN = 1'b1;
        mon_en = 1;
        set_v(3, 1, 8, 6, 1, 9);
        do_cmd(1, -1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
